// File: rtl/branch_predictor_pkg.sv
// Shared pipeline constants: conditional-branch opcode and the 2-bit
// saturating-counter encodings used by the branch history table.
package branch_predictor_pkg;

    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bht_state_e;

endpackage

// File: rtl/bht_counter.sv
// One 2-bit saturating counter of the branch history table.
// Counts up on a taken update and down on a not-taken update; resets to WEAK_NT.
module bht_counter
    import branch_predictor_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       inc_i,
    output logic [1:0] state_o
);

    logic [1:0] state_q;
    logic [1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            if (inc_i && (state_q != STRONG_T)) begin
                state_d = state_q + 2'd1;
            end else if (!inc_i && (state_q != STRONG_NT)) begin
                state_d = state_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WEAK_NT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: PC-indexed table of 2-bit counters with a
// zero-latency lookup, B-type target adder and resolved/mispredict statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] IF_pc,
    input  logic [31:0]     IF_instruction,
    input  logic            EX_update_valid,
    input  logic [XLEN-1:0] EX_pc,
    input  logic            EX_taken,
    input  logic            EX_mispredict,
    output logic            IF_branch_estimation,
    output logic [XLEN-1:0] IF_branch_target,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ctr_state [BHT_ENTRIES];
    logic [XLEN-1:0]  b_imm;
    logic             is_branch;

    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    // Word-aligned PC bits select the entry; upper bits alias freely.
    assign if_idx = IF_pc[IDX_W+1:2];
    assign ex_idx = EX_pc[IDX_W+1:2];

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        bht_counter u_ctr (
            .clk     (clk),
            .reset   (reset),
            .en_i    (EX_update_valid && (ex_idx == IDX_W'(i))),
            .inc_i   (EX_taken),
            .state_o (ctr_state[i])
        );
    end

    assign is_branch = (IF_instruction[6:0] == BRANCH_OPCODE);
    assign IF_branch_estimation = !reset && is_branch && ctr_state[if_idx][1];

    assign b_imm = {{(XLEN-13){IF_instruction[31]}}, IF_instruction[31], IF_instruction[7],
                    IF_instruction[30:25], IF_instruction[11:8], 1'b0};
    assign IF_branch_target = IF_pc + b_imm;

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (EX_update_valid) begin
            if (branch_count_q != 32'hFFFF_FFFF) begin
                branch_count_d = branch_count_q + 32'd1;
            end
            if (EX_mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    logic unused_bits;
    assign unused_bits = ^{EX_pc[XLEN-1:IDX_W+2], EX_pc[1:0], IF_instruction[24:12]};

endmodule
